// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/rbs.sv
// Ripple-borrow subtractor: d = a - b - bin, built from a chain of full-subtractor cells.
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

module rbs #(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] d,
  output logic         bout
);

  logic [N:0] br;

  assign br[0] = bin;
  assign bout  = br[N];

  for (genvar i = 0; i < N; i++) begin : g_cell
    fs_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (br[i]),
      .d    (d[i]),
      .bout (br[i+1])
    );
  end

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/busy/done handshake.
module seq_restoring_div
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  div_state_t       state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dreg;

  logic             accept;
  logic             last_iter;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;
  logic             unused_r_msb;

  assign accept       = start && (state == S_IDLE || state == S_DONE);
  assign last_iter    = (cnt == CW'(WIDTH - 1));
  assign shifted      = {r[WIDTH-1:0], q[WIDTH-1]};
  assign unused_r_msb = r[WIDTH];

  rbs #(.N(WIDTH + 1)) u_rbs (
    .a    (shifted),
    .b    ({1'b0, dreg}),
    .bin  (1'b0),
    .d    (diff),
    .bout (borrow)
  );

  // A borrow means the trial subtraction went negative, so keep the shifted value.
  assign r_next = borrow ? shifted : diff;
  assign q_next = {q[WIDTH-2:0], ~borrow};

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start)
          state_next = (divisor == '0) ? S_DONE : S_RUN;
        else
          state_next = S_IDLE;
      end
      S_RUN: begin
        if (last_iter)
          state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      r           <= '0;
      q           <= '0;
      dreg        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        dreg <= divisor;
        q    <= dividend;
        r    <= '0;
        cnt  <= '0;
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          div_by_zero <= 1'b0;
        end
      end else if (state == S_RUN) begin
        r   <= r_next;
        q   <= q_next;
        cnt <= cnt + 1'b1;
        // Results publish on the final iteration so they are visible in the done cycle.
        if (last_iter) begin
          quotient  <= q_next;
          remainder <= r_next[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_div.sv
// Self-checking bench for seq_restoring_div: directed scenarios plus a random sweep
// compared against plain integer division.
module tb_seq_restoring_div;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  int testCount = 0;
  int failCount = 0;

  seq_restoring_div #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int observed, input int expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drives one start pulse; returns just after the accepting edge (now in T0+1).
  task automatic applyStimulus(input int dvd, input int dvs);
    @(negedge clk);
    start    = 1'b1;
    dividend = WIDTH'(dvd);
    divisor  = WIDTH'(dvs);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int expLat, input bit checkBusy);
    int lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (checkBusy) begin
        chk({tag, "_busy"}, int'(busy), (k < expLat) ? 1 : 0);
        chk({tag, "_done"}, int'(done), (k == expLat) ? 1 : 0);
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, expLat);
  endtask

  task automatic checkOutput(input string tag, input int dvd, input int dvs);
    if (dvs == 0) begin
      chk({tag, "_quot"}, int'(quotient), 255);
      chk({tag, "_rem"}, int'(remainder), dvd);
      chk({tag, "_dbz"}, int'(div_by_zero), 1);
    end else begin
      chk({tag, "_quot"}, int'(quotient), dvd / dvs);
      chk({tag, "_rem"}, int'(remainder), dvd % dvs);
      chk({tag, "_dbz"}, int'(div_by_zero), 0);
    end
  endtask

  task automatic runOp(input string tag, input int dvd, input int dvs, input bit checkBusy);
    applyStimulus(dvd, dvs);
    waitDone(tag, (dvs == 0) ? 1 : WIDTH + 1, checkBusy);
    checkOutput(tag, dvd, dvs);
  endtask

  initial begin
    int a, b, lat;
    bit sawDone;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_quot", int'(quotient), 0);
    chk("reset_rem", int'(remainder), 0);
    chk("reset_dbz", int'(div_by_zero), 0);
    rst = 1'b0;

    runOp("t1_100_7", 100, 7, 1'b1);
    runOp("t2_255_1", 255, 1, 1'b1);
    runOp("t2_5_9", 5, 9, 1'b1);
    runOp("t3_37_0", 37, 0, 1'b1);
    runOp("t3_8_2", 8, 2, 1'b1);

    // Start pulsed mid-run is ignored; start held in the done cycle is taken.
    applyStimulus(200, 3);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; dividend = 8'd9; divisor = 8'd9;
      end else if (k == 4) begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("t4_latency", lat, WIDTH + 1);
    checkOutput("t4_200_3", 200, 3);
    start = 1'b1; dividend = 8'd9; divisor = 8'd9;
    @(posedge clk);
    #1 start = 1'b0;
    waitDone("t4_9_9", WIDTH + 1, 1'b1);
    checkOutput("t4_9_9", 9, 9);

    // Reset in the middle of a run aborts it without a done pulse.
    applyStimulus(100, 7);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_quot", int'(quotient), 0);
    chk("t5_rem", int'(remainder), 0);
    chk("t5_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    sawDone = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) sawDone = 1'b1;
    end
    chk("t5_no_done", int'(sawDone), 0);
    runOp("t5_50_6", 50, 6, 1'b1);

    for (int i = 0; i < 1000; i++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(1, 255));
      runOp("rand", a, b, 1'b0);
      chk("rand_invariant", int'(quotient) * b + int'(remainder), a);
      chk("rand_rem_lt_div", (int'(remainder) < b) ? 1 : 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
